// File: rtl/hazard_detection_unit_if.sv
// hazard_detection_unit_if: hazard inputs from IF/ID/EX and pipeline control outputs
interface hazard_detection_unit_if #(
  parameter int NB_ADDR = 5,
  parameter int NB_CNT  = 16
);
  logic [NB_ADDR-1:0] i_rs_from_if_id;
  logic [NB_ADDR-1:0] i_rt_from_if_id;
  logic [NB_ADDR-1:0] i_rt_from_id_ex;
  logic               i_uses_rs_from_id;
  logic               i_uses_rt_from_id;
  logic               i_mem_read_from_id_ex;
  logic               i_branch_taken_from_ex;
  logic               i_halt_from_id;
  logic               i_clear_count;
  logic               o_pc_wr_enb;
  logic               o_if_id_wr_enb;
  logic               o_if_id_flush;
  logic               o_id_ex_bubble;
  logic               o_halted;
  logic [NB_CNT-1:0]  o_stall_count;
  logic [NB_CNT-1:0]  o_flush_count;
  modport master (
    output i_rs_from_if_id, i_rt_from_if_id, i_rt_from_id_ex, i_uses_rs_from_id, i_uses_rt_from_id,
           i_mem_read_from_id_ex, i_branch_taken_from_ex, i_halt_from_id, i_clear_count,
    input  o_pc_wr_enb, o_if_id_wr_enb, o_if_id_flush, o_id_ex_bubble, o_halted,
           o_stall_count, o_flush_count
  );
  modport slave (
    input  i_rs_from_if_id, i_rt_from_if_id, i_rt_from_id_ex, i_uses_rs_from_id, i_uses_rt_from_id,
           i_mem_read_from_id_ex, i_branch_taken_from_ex, i_halt_from_id, i_clear_count,
    output o_pc_wr_enb, o_if_id_wr_enb, o_if_id_flush, o_id_ex_bubble, o_halted,
           o_stall_count, o_flush_count
  );
endinterface

// File: rtl/hazard_detection_unit.sv
// hazard_detection_unit: load-use stall, taken-branch flush and halt drain control with event counters
module hazard_detection_unit #(
  parameter int NB_ADDR      = 5,
  parameter int NB_CNT       = 16,
  parameter int DRAIN_CYCLES = 3
) (
  input logic                    i_clock,
  input logic                    i_reset,
  hazard_detection_unit_if.slave bus
);
  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
  state_t            state_q, state_d;
  logic [3:0]        drain_q, drain_d;
  logic [NB_CNT-1:0] stall_q, stall_d, flush_q, flush_d;
  logic              load_use, run, flush_ev, stall_ev, halt_ev, hold;
  assign load_use = bus.i_mem_read_from_id_ex && (bus.i_rt_from_id_ex != NB_ADDR'(0)) &&
                    ((bus.i_uses_rs_from_id && bus.i_rt_from_id_ex == bus.i_rs_from_if_id) ||
                     (bus.i_uses_rt_from_id && bus.i_rt_from_id_ex == bus.i_rt_from_if_id));
  // events are masked while reset is held so outputs show the idle RUN values
  assign run      = i_reset && state_q == RUN;
  assign flush_ev = run && bus.i_branch_taken_from_ex;
  assign stall_ev = run && !bus.i_branch_taken_from_ex && load_use;
  assign halt_ev  = run && !bus.i_branch_taken_from_ex && !load_use && bus.i_halt_from_id;
  assign hold     = i_reset && (state_q != RUN || stall_ev || halt_ev);
  always_comb begin
    state_d = halt_ev ? DRAIN : state_q;
    drain_d = halt_ev ? 4'(DRAIN_CYCLES - 1) : drain_q;
    if (state_q == DRAIN) begin
      state_d = drain_q == 4'd0 ? HALTED : DRAIN;
      drain_d = drain_q == 4'd0 ? 4'd0 : drain_q - 4'd1;
    end
  end
  always_comb begin
    stall_d = bus.i_clear_count ? '0 : (stall_ev && !(&stall_q)) ? stall_q + NB_CNT'(1) : stall_q;
    flush_d = bus.i_clear_count ? '0 : (flush_ev && !(&flush_q)) ? flush_q + NB_CNT'(1) : flush_q;
  end
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= RUN;
      drain_q <= 4'd0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end
  assign bus.o_pc_wr_enb    = !hold;
  assign bus.o_if_id_wr_enb = !hold;
  assign bus.o_if_id_flush  = flush_ev;
  assign bus.o_id_ex_bubble = flush_ev || hold;
  assign bus.o_halted       = state_q == HALTED;
  assign bus.o_stall_count  = stall_q;
  assign bus.o_flush_count  = flush_q;
endmodule

// File: tb/tb_hazard_detection_unit.sv
// tb_hazard_detection_unit: randomized and directed checks against a behavioural pipeline-control model
module tb_hazard_detection_unit;
  localparam int NA = 5;
  localparam int NC = 4;
  localparam int DC = 3;
  localparam int SAT = (1 << NC) - 1;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  hazard_detection_unit_if #(.NB_ADDR(NA), .NB_CNT(NC)) bus ();
  hazard_detection_unit #(.NB_ADDR(NA), .NB_CNT(NC), .DRAIN_CYCLES(DC)) dut (
    .i_clock(clk), .i_reset(rst_n), .bus(bus.slave)
  );
  int compared = 0;
  int mismatched = 0;
  bit check_en = 1'b0;
  // model: drain cycles still to spend, halted flag, event counts
  int m_drain, m_stall, m_flush;
  bit m_halted;
  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  function automatic bit lu();
    int rte, rs, rt;
    rte = int'(bus.i_rt_from_id_ex);
    rs  = int'(bus.i_rs_from_if_id);
    rt  = int'(bus.i_rt_from_if_id);
    return bus.i_mem_read_from_id_ex && rte != 0 &&
           ((bus.i_uses_rs_from_id && rte == rs) || (bus.i_uses_rt_from_id && rte == rt));
  endfunction
  function automatic bit running();
    return !m_halted && m_drain == 0;
  endfunction
  // {pc_wr, if_id_wr, flush, bubble, halted}
  function automatic logic [4:0] exp_ctl();
    if (!rst_n) return 5'b11000;
    if (!running()) return {4'b0001, m_halted};
    if (bus.i_branch_taken_from_ex) return 5'b11110;
    if (lu() || bus.i_halt_from_id) return 5'b00010;
    return 5'b11000;
  endfunction
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_drain  <= 0;
      m_halted <= 1'b0;
      m_stall  <= 0;
      m_flush  <= 0;
    end else begin
      if (m_drain > 0) begin
        m_drain <= m_drain - 1;
        if (m_drain == 1) m_halted <= 1'b1;
      end else if (running() && !bus.i_branch_taken_from_ex && !lu() && bus.i_halt_from_id)
        m_drain <= DC;
      m_stall <= bus.i_clear_count ? 0 :
                 (running() && !bus.i_branch_taken_from_ex && lu()) ? (m_stall == SAT ? SAT : m_stall + 1) : m_stall;
      m_flush <= bus.i_clear_count ? 0 :
                 (running() && bus.i_branch_taken_from_ex) ? (m_flush == SAT ? SAT : m_flush + 1) : m_flush;
    end
  end
  always @(negedge clk) begin
    #3;
    if (check_en) begin
      chk("pc_wr_enb", int'(bus.o_pc_wr_enb), int'(exp_ctl() >> 4) & 1);
      chk("if_id_wr_enb", int'(bus.o_if_id_wr_enb), int'(exp_ctl() >> 3) & 1);
      chk("if_id_flush", int'(bus.o_if_id_flush), int'(exp_ctl() >> 2) & 1);
      chk("id_ex_bubble", int'(bus.o_id_ex_bubble), int'(exp_ctl() >> 1) & 1);
      chk("halted", int'(bus.o_halted), int'(exp_ctl()) & 1);
      chk("stall_count", int'(bus.o_stall_count), m_stall);
      chk("flush_count", int'(bus.o_flush_count), m_flush);
    end
  end
  task automatic drive(input bit mr, input int rte, input int rs, input int urs,
                       input bit br, input bit h, input bit clr);
    @(negedge clk);
    #1;
    bus.i_mem_read_from_id_ex  = mr;
    bus.i_rt_from_id_ex        = NA'(rte);
    bus.i_rs_from_if_id        = NA'(rs);
    bus.i_rt_from_if_id        = NA'(0);
    bus.i_uses_rs_from_id      = urs[0];
    bus.i_uses_rt_from_id      = 1'b0;
    bus.i_branch_taken_from_ex = br;
    bus.i_halt_from_id         = h;
    bus.i_clear_count          = clr;
    #1;
  endtask
  task automatic idle();
    drive(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic rand_drive();
    @(negedge clk);
    #1;
    bus.i_mem_read_from_id_ex  = 1'($urandom_range(0, 1));
    bus.i_rt_from_id_ex        = NA'($urandom_range(0, 3));
    bus.i_rs_from_if_id        = NA'($urandom_range(0, 3));
    bus.i_rt_from_if_id        = NA'($urandom_range(0, 3));
    bus.i_uses_rs_from_id      = 1'($urandom_range(0, 1));
    bus.i_uses_rt_from_id      = 1'($urandom_range(0, 1));
    bus.i_branch_taken_from_ex = $urandom_range(0, 5) == 0;
    bus.i_halt_from_id         = $urandom_range(0, 24) == 0;
    bus.i_clear_count          = $urandom_range(0, 39) == 0;
  endtask
  initial begin
    bus.i_mem_read_from_id_ex  = 1'b1;
    bus.i_rt_from_id_ex        = NA'(5);
    bus.i_rs_from_if_id        = NA'(5);
    bus.i_rt_from_if_id        = NA'(0);
    bus.i_uses_rs_from_id      = 1'b1;
    bus.i_uses_rt_from_id      = 1'b0;
    bus.i_branch_taken_from_ex = 1'b1;
    bus.i_halt_from_id         = 1'b1;
    bus.i_clear_count          = 1'b0;
    #2;
    chk("reset pc_wr_enb", int'(bus.o_pc_wr_enb), 1);
    chk("reset flush", int'(bus.o_if_id_flush), 0);
    chk("reset bubble", int'(bus.o_id_ex_bubble), 0);
    chk("reset halted", int'(bus.o_halted), 0);
    chk("reset stall_count", int'(bus.o_stall_count), 0);
    check_en = 1'b1;
    idle();
    rst_n = 1'b1;
    drive(1'b1, 5, 5, 1, 1'b0, 1'b0, 1'b0);
    chk("load_use pc_wr_enb", int'(bus.o_pc_wr_enb), 0);
    chk("load_use bubble", int'(bus.o_id_ex_bubble), 1);
    idle();
    chk("load_use stall_count", int'(bus.o_stall_count), 1);
    drive(1'b1, 0, 0, 1, 1'b0, 1'b0, 1'b0);
    chk("r0 pc_wr_enb", int'(bus.o_pc_wr_enb), 1);
    idle();
    chk("r0 stall_count", int'(bus.o_stall_count), 1);
    drive(1'b1, 5, 5, 1, 1'b1, 1'b1, 1'b0);
    chk("prio flush", int'(bus.o_if_id_flush), 1);
    chk("prio bubble", int'(bus.o_id_ex_bubble), 1);
    chk("prio pc_wr_enb", int'(bus.o_pc_wr_enb), 1);
    idle();
    chk("prio flush_count", int'(bus.o_flush_count), 1);
    chk("prio stall_count", int'(bus.o_stall_count), 1);
    chk("prio still RUN", int'(bus.o_pc_wr_enb), 1);
    repeat (20) drive(1'b1, 5, 5, 1, 1'b0, 1'b0, 1'b0);
    idle();
    chk("saturated stall_count", int'(bus.o_stall_count), 15);
    drive(1'b0, 0, 0, 0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < DC; i++) begin
      drive(1'b0, 0, 0, 0, 1'b1, 1'b0, 1'b0);
      chk("drain halted", int'(bus.o_halted), 0);
      chk("drain ignores branch", int'(bus.o_if_id_flush), 0);
      chk("drain pc_wr_enb", int'(bus.o_pc_wr_enb), 0);
    end
    repeat (3) begin
      drive(1'b1, 5, 5, 1, 1'b1, 1'b0, 1'b0);
      chk("halted held", int'(bus.o_halted), 1);
      chk("halted flush_count", int'(bus.o_flush_count), 1);
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset halted", int'(bus.o_halted), 0);
    chk("async reset pc_wr_enb", int'(bus.o_pc_wr_enb), 1);
    chk("async reset stall_count", int'(bus.o_stall_count), 0);
    chk("async reset flush_count", int'(bus.o_flush_count), 0);
    idle();
    rst_n = 1'b1;
    repeat (3) drive(1'b1, 5, 5, 1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 5, 5, 1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 5, 5, 1, 1'b0, 1'b0, 1'b1);
    idle();
    chk("clear stall_count", int'(bus.o_stall_count), 0);
    chk("clear flush_count", int'(bus.o_flush_count), 0);
    for (int i = 0; i < 3000; i++) begin
      rand_drive();
      if (i % 60 == 59) begin
        #($urandom_range(1, 2));
        rst_n = 1'b0;
      end else if (i % 60 == 0 && i != 0) begin
        rst_n = 1'b1;
      end
    end
    rst_n = 1'b1;
    idle();
    idle();
    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
